pipeline_hazard_ctrl: RTL

- Control-side counterpart of the ID/EX latch. It reads the latched EX-stage control fields (dREN, RegWr, wsel, jumpFlush, halt) alongside ID-stage register selects and cache hit signals.
- It drives the enable/flush inputs of the IF/ID, ID/EX and EX/MEM latches and the PC enable.
- It owns load-use stalls, memory-wait freezes, jump/branch flushes and the halt drain sequence.
- It sits in the datapath beside the pipeline latches.

---
 rtl/pipeline_hazard_ctrl_if.sv | 38 +++
 rtl/pipeline_hazard_ctrl.sv | 136 +++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// Signal bundle between the pipeline latches/datapath (master) and the hazard controller (slave).
// Carries the ID/EX control fields and cache status in, and the latch/PC enables and flushes out.
interface pipeline_hazard_ctrl_if #(
    parameter int STALL_CNT_W = 16
);
    logic [4:0]             rs_id;
    logic [4:0]             rt_id;
    logic                   uses_rt_id;
    logic                   dREN_ex;
    logic                   RegWr_ex;
    logic [4:0]             wsel_ex;
    logic                   jumpFlush_ex;
    logic                   branch_taken_ex;
    logic                   halt_ex;
    logic                   dmemreq_mem;
    logic                   dhit;
    logic                   ihit;
    logic                   pc_en;
    logic                   ifid_en;
    logic                   ifid_flush;
    logic                   idex_en;
    logic                   idex_flush;
    logic                   exmem_en;
    logic                   halted;
    logic [STALL_CNT_W-1:0] stall_cnt;

    modport master (
        output rs_id, rt_id, uses_rt_id, dREN_ex, RegWr_ex, wsel_ex, jumpFlush_ex,
               branch_taken_ex, halt_ex, dmemreq_mem, dhit, ihit,
        input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, halted, stall_cnt
    );

    modport slave (
        input  rs_id, rt_id, uses_rt_id, dREN_ex, RegWr_ex, wsel_ex, jumpFlush_ex,
               branch_taken_ex, halt_ex, dmemreq_mem, dhit, ihit,
        output pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, halted, stall_cnt
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, memory-wait freezes, jump/branch flushes
// and the halt drain sequence, driving the IF/ID, ID/EX, EX/MEM latch controls and PC enable.
module pipeline_hazard_ctrl #(
    parameter int DRAIN_CYCLES = 3,
    parameter int STALL_CNT_W  = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    pipeline_hazard_ctrl_if.slave hz
);

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        S_RESET,
        S_RUN,
        S_DRAIN,
        S_HALTED
    } state_t;

    state_t                 state;
    logic [DW-1:0]          drain_cnt;
    logic [STALL_CNT_W-1:0] stall_cnt;

    logic mem_wait;
    logic load_use;
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_en;
    logic idex_flush;
    logic exmem_en;
    logic halted;

    function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
        if (&v) return v;
        return v + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    endfunction

    assign mem_wait = hz.dmemreq_mem & ~hz.dhit;

    // Register 0 is hard-wired, so a load targeting it can never create a dependency.
    assign load_use = hz.dREN_ex & hz.RegWr_ex & (hz.wsel_ex != 5'd0) &
                      ((hz.wsel_ex == hz.rs_id) | (hz.uses_rt_id & (hz.wsel_ex == hz.rt_id)));

    always_comb begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        ifid_flush = 1'b0;
        idex_en    = 1'b0;
        idex_flush = 1'b0;
        exmem_en   = 1'b0;
        halted     = 1'b0;
        case (state)
            S_RESET: begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end
            S_RUN: begin
                if (mem_wait) begin
                    // Full freeze: every latch holds so the blocked condition is re-seen next cycle.
                end else if (hz.halt_ex) begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                    exmem_en   = 1'b1;
                end else if (hz.jumpFlush_ex | hz.branch_taken_ex) begin
                    pc_en      = 1'b1;
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                    exmem_en   = 1'b1;
                end else if (load_use) begin
                    idex_flush = 1'b1;
                    exmem_en   = 1'b1;
                end else if (!hz.ihit) begin
                    ifid_flush = 1'b1;
                    idex_en    = 1'b1;
                    exmem_en   = 1'b1;
                end else begin
                    pc_en    = 1'b1;
                    ifid_en  = 1'b1;
                    idex_en  = 1'b1;
                    exmem_en = 1'b1;
                end
            end
            S_DRAIN: begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
                exmem_en   = ~mem_wait;
            end
            default: begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
                halted     = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= S_RESET;
            drain_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            case (state)
                S_RESET: state <= S_RUN;
                S_RUN: begin
                    if (!pc_en) stall_cnt <= sat_inc(stall_cnt);
                    if (!mem_wait && hz.halt_ex) begin
                        state     <= S_DRAIN;
                        drain_cnt <= DRAIN_LOAD;
                    end
                end
                S_DRAIN: begin
                    // The drain only advances on cycles where EX/MEM actually moves.
                    if (!mem_wait) begin
                        if (drain_cnt == '0) state <= S_HALTED;
                        else drain_cnt <= drain_cnt - DW'(1);
                    end
                end
                S_HALTED: state <= S_HALTED;
                default:  state <= S_RESET;
            endcase
        end
    end

    assign hz.pc_en      = pc_en;
    assign hz.ifid_en    = ifid_en;
    assign hz.ifid_flush = ifid_flush;
    assign hz.idex_en    = idex_en;
    assign hz.idex_flush = idex_flush;
    assign hz.exmem_en   = exmem_en;
    assign hz.halted     = halted;
    assign hz.stall_cnt  = stall_cnt;

endmodule
